// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback record and helpers for the writeback arbiter slice.
// Pure types and constants; no latency or flow control of its own.
package writeback_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  regdest;
    logic        writereg;
    logic [31:0] wbvalue;
  } wb_t;

  localparam wb_t WB_IDLE = '{regdest: REG_ZERO, writereg: 1'b0, wbvalue: 32'd0};

  // r0 is hardwired, so a write to it is treated as no request at all
  function automatic logic wb_valid(input wb_t r);
    return r.writereg && (r.regdest != REG_ZERO);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// X/Y result buses in, register-file write port and status out.
// The interface adds no latency; wb_is_stall is advisory backpressure toward issue.
interface writeback_arbiter_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [4:0]    x_wb_regdest;
  logic          x_wb_writereg;
  logic [31:0]   x_wb_wbvalue;
  logic [4:0]    y_wb_regdest;
  logic          y_wb_writereg;
  logic [31:0]   y_wb_wbvalue;
  logic [4:0]    wb_rf_regdest;
  logic          wb_rf_writereg;
  logic [31:0]   wb_rf_wbvalue;
  logic          wb_is_stall;
  logic          wb_overflow;
  logic [CW-1:0] wb_count;

  modport master (
    output x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    output y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    input  wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue,
    input  wb_is_stall, wb_overflow, wb_count
  );

  modport slave (
    input  x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    input  y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    output wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue,
    output wb_is_stall, wb_overflow, wb_count
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Pending-write FIFO, two pushes and one pop per cycle; head visible combinationally.
// Push-to-head 1 cycle; no internal backpressure, the caller must never overfill it.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push0_vld,
  input  wb_t                      push0_dat,
  input  logic                     push1_vld,
  input  wb_t                      push1_dat,
  input  logic                     pop,
  output wb_t                      head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_t           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    n_push;

  assign n_push   = {1'b0, push0_vld} + {1'b0, push1_vld};
  assign head_dat = mem[rd_ptr];

  // push1 is only ever raised together with push0, so it lands one slot later
  always_ff @(posedge clock) begin
    if (push0_vld) mem[wr_ptr] <= push0_dat;
    if (push1_vld) mem[wr_ptr + PW'(1)] <= push1_dat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges X and Y results into one register-file write port, oldest pending first.
// 1-cycle latency when empty; inputs are never stalled: wb_is_stall advises issue, excess X is dropped.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STALL_LEVEL = 3
) (
  input  logic                clock,
  input  logic                reset,
  writeback_arbiter_if.slave  wb
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(STALL_LEVEL);

  wb_t           x_req;
  wb_t           y_req;
  logic          x_vld;
  logic          y_vld;
  logic [CW-1:0] count;
  wb_t           head_dat;
  logic          pop;
  logic          push0_vld;
  logic          push1_vld;
  wb_t           push0_dat;
  logic          drop;
  wb_t           rf_d;
  wb_t           rf_q;
  logic          overflow_q;

  assign x_req = '{regdest: wb.x_wb_regdest, writereg: wb.x_wb_writereg, wbvalue: wb.x_wb_wbvalue};
  assign y_req = '{regdest: wb.y_wb_regdest, writereg: wb.y_wb_writereg, wbvalue: wb.y_wb_wbvalue};
  assign x_vld = wb_valid(x_req);
  assign y_vld = wb_valid(y_req);

  // Candidate order is FIFO head, then Y, then X; the first one goes to the RF.
  always_comb begin
    pop       = (count != '0);
    rf_d      = WB_IDLE;
    push0_vld = 1'b0;
    push0_dat = x_req;
    push1_vld = 1'b0;
    drop      = 1'b0;
    if (pop) begin
      rf_d      = head_dat;
      push0_vld = y_vld || x_vld;
      push0_dat = y_vld ? y_req : x_req;
      // the pop frees exactly one slot, so only the trailing X can be lost
      push1_vld = y_vld && x_vld && (count != FULL_CNT);
      drop      = y_vld && x_vld && (count == FULL_CNT);
    end else if (y_vld) begin
      rf_d      = y_req;
      push0_vld = x_vld;
    end else if (x_vld) begin
      rf_d      = x_req;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clock     (clock),
    .reset     (reset),
    .push0_vld (push0_vld),
    .push0_dat (push0_dat),
    .push1_vld (push1_vld),
    .push1_dat (x_req),
    .pop       (pop),
    .head_dat  (head_dat),
    .count     (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_q       <= WB_IDLE;
      overflow_q <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      overflow_q <= overflow_q || drop;
    end
  end

  assign wb.wb_rf_regdest  = rf_q.regdest;
  assign wb.wb_rf_writereg = rf_q.writereg;
  assign wb.wb_rf_wbvalue  = rf_q.wbvalue;
  assign wb.wb_overflow    = overflow_q;
  assign wb.wb_count       = count;
  assign wb.wb_is_stall    = (count >= STALL_CNT);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random vs queue model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 8;
  localparam int STALL = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  writeback_arbiter_if #(.DEPTH(DEPTH)) wb();

  writeback_arbiter #(.DEPTH(DEPTH), .STALL_LEVEL(STALL)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes as a plain queue
  wb_t  mq[$];
  wb_t  m_rf;
  logic m_ovf;

  typedef struct {
    logic [4:0]  y_rd;
    logic        y_we;
    logic [31:0] y_val;
    logic [4:0]  x_rd;
    logic        x_we;
    logic [31:0] x_val;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [31:0] e_val;
    int          e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic wb_t mk(input logic [4:0] rd, input logic we, input logic [31:0] val);
    wb_t r;
    r.regdest  = rd;
    r.writereg = we;
    r.wbvalue  = val;
    return r;
  endfunction

  function automatic bit is_req(input wb_t r);
    return (r.writereg == 1'b1) && (r.regdest != 5'd0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rf  = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input wb_t y, input wb_t x);
    wb_t cand[$];
    cand = mq;
    if (is_req(y)) cand.push_back(y);
    if (is_req(x)) cand.push_back(x);
    if (cand.size() == 0) m_rf = '0;
    else m_rf = cand.pop_front();
    while (cand.size() > DEPTH) begin
      void'(cand.pop_back());
      m_ovf = 1'b1;
    end
    mq = cand;
  endtask

  task automatic drive(input wb_t y, input wb_t x);
    wb.y_wb_regdest  = y.regdest;
    wb.y_wb_writereg = y.writereg;
    wb.y_wb_wbvalue  = y.wbvalue;
    wb.x_wb_regdest  = x.regdest;
    wb.x_wb_writereg = x.writereg;
    wb.x_wb_wbvalue  = x.wbvalue;
  endtask

  task automatic cycle(input wb_t y, input wb_t x);
    drive(y, x);
    @(posedge clock);
    model_step(y, x);
    #1;
  endtask

  function automatic logic [63:0] rf_now();
    return 64'({wb.wb_rf_regdest, wb.wb_rf_writereg, wb.wb_rf_wbvalue});
  endfunction

  task automatic check_model(input string tag);
    check({tag, " rf"},    rf_now(), 64'(m_rf));
    check({tag, " count"}, 64'(wb.wb_count), 64'(mq.size()));
    check({tag, " stall"}, 64'(wb.wb_is_stall), 64'(mq.size() >= STALL));
    check({tag, " ovf"},   64'(wb.wb_overflow), 64'(m_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #3;
    reset = 1'b1;
  endtask

  initial begin
    wb_t idle;
    idle = mk(5'd0, 1'b0, 32'd0);
    model_reset();
    drive(idle, idle);

    // reset state
    #12;
    check("reset rf",    rf_now(), 64'd0);
    check("reset count", 64'(wb.wb_count), 64'd0);
    check("reset stall", 64'(wb.wb_is_stall), 64'd0);
    check("reset ovf",   64'(wb.wb_overflow), 64'd0);
    reset = 1'b1;

    // directed table: {Y in, X in, expected RF write, expected count}
    tbl[0] = '{5'd0,  1'b0, 32'h0,        5'd5,  1'b1, 32'h11, 5'd5,  1'b1, 32'h11,       0};
    tbl[1] = '{5'd3,  1'b1, 32'h64,       5'd3,  1'b1, 32'h7,  5'd3,  1'b1, 32'h64,       1};
    tbl[2] = '{5'd0,  1'b0, 32'h0,        5'd0,  1'b0, 32'h0,  5'd3,  1'b1, 32'h7,        0};
    tbl[3] = '{5'd9,  1'b0, 32'h99,       5'd0,  1'b1, 32'h55, 5'd0,  1'b0, 32'h0,        0};
    tbl[4] = '{5'd0,  1'b0, 32'h0,        5'd0,  1'b0, 32'h0,  5'd0,  1'b0, 32'h0,        0};
    tbl[5] = '{5'd31, 1'b1, 32'hDEADBEEF, 5'd0,  1'b0, 32'h0,  5'd31, 1'b1, 32'hDEADBEEF, 0};
    tbl[6] = '{5'd1,  1'b1, 32'hA,        5'd2,  1'b1, 32'hB,  5'd1,  1'b1, 32'hA,        1};
    tbl[7] = '{5'd4,  1'b1, 32'hC,        5'd0,  1'b0, 32'h0,  5'd2,  1'b1, 32'hB,        1};
    tbl[8] = '{5'd0,  1'b0, 32'h0,        5'd6,  1'b1, 32'hD,  5'd4,  1'b1, 32'hC,        1};
    tbl[9] = '{5'd0,  1'b0, 32'h0,        5'd0,  1'b0, 32'h0,  5'd6,  1'b1, 32'hD,        0};
    for (int i = 0; i < 10; i++) begin
      cycle(mk(tbl[i].y_rd, tbl[i].y_we, tbl[i].y_val), mk(tbl[i].x_rd, tbl[i].x_we, tbl[i].x_val));
      check($sformatf("vec%0d rf", i), rf_now(), 64'({tbl[i].e_rd, tbl[i].e_we, tbl[i].e_val}));
      check($sformatf("vec%0d count", i), 64'(wb.wb_count), 64'(tbl[i].e_cnt));
      check($sformatf("vec%0d ovf", i), 64'(wb.wb_overflow), 64'd0);
    end

    // backpressure: three collisions, then drain
    for (int k = 1; k <= 3; k++) begin
      cycle(mk(5'd1, 1'b1, 32'h10 + k), mk(5'd2, 1'b1, 32'h20 + k));
      check($sformatf("bp fill%0d count", k), 64'(wb.wb_count), 64'(k));
      check($sformatf("bp fill%0d stall", k), 64'(wb.wb_is_stall), 64'(k >= 3));
      check_model($sformatf("bp fill%0d", k));
    end
    for (int k = 2; k >= 0; k--) begin
      cycle(idle, idle);
      check($sformatf("bp drain%0d count", k), 64'(wb.wb_count), 64'(k));
      check($sformatf("bp drain%0d stall", k), 64'(wb.wb_is_stall), 64'd0);
      check_model($sformatf("bp drain%0d", k));
    end

    // overflow: fill to DEPTH then one more collision
    for (int k = 1; k <= 9; k++) begin
      cycle(mk(5'd1, 1'b1, 32'h100 + k), mk(5'd2, 1'b1, 32'h200 + k));
      check($sformatf("of fill%0d count", k), 64'(wb.wb_count), 64'((k > 8) ? 8 : k));
      check($sformatf("of fill%0d ovf", k), 64'(wb.wb_overflow), 64'(k == 9));
      check_model($sformatf("of fill%0d", k));
    end
    for (int k = 0; k < 8; k++) begin
      cycle(idle, idle);
      check_model($sformatf("of drain%0d", k));
    end
    check("of last write Y9", rf_now(), 64'({5'd1, 1'b1, 32'h109}));
    check("of sticky", 64'(wb.wb_overflow), 64'd1);
    cycle(idle, idle);
    check("of empty rf", rf_now(), 64'd0);

    // async reset between edges with five pending entries
    for (int k = 1; k <= 5; k++) cycle(mk(5'd3, 1'b1, 32'h300 + k), mk(5'd4, 1'b1, 32'h400 + k));
    check("ar pre count", 64'(wb.wb_count), 64'd5);
    #3;
    reset = 1'b0;
    #1;
    check("ar rf",    rf_now(), 64'd0);
    check("ar count", 64'(wb.wb_count), 64'd0);
    check("ar stall", 64'(wb.wb_is_stall), 64'd0);
    check("ar ovf",   64'(wb.wb_overflow), 64'd0);
    model_reset();
    #2;
    reset = 1'b1;
    cycle(idle, mk(5'd7, 1'b1, 32'h77));
    check("ar post rf",    rf_now(), 64'({5'd7, 1'b1, 32'h77}));
    check("ar post count", 64'(wb.wb_count), 64'd0);

    // random traffic, alternating heavy and light phases
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int we_pct;
      wb_t ry;
      wb_t rx;
      we_pct = ((i / 50) % 2 == 0) ? 85 : 20;
      ry = mk(5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < we_pct), $urandom);
      rx = mk(5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < we_pct), $urandom);
      cycle(ry, rx);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
